// File: rtl/ofm_stream_tx.sv
// rtl/ofm_stream_tx.sv - drains result BRAM banks into an AXI-Stream master
// Reads are issued against a credit of FIFO occupancy plus the in-flight read so the 4-deep FIFO never overflows.
module ofm_stream_tx #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_BANK   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_WIDTH:0]          word_cnt,
  input  logic [3:0]                   bank_num,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_BANK-1:0]          en_rd,
  output logic [ADDR_WIDTH-1:0]        addr_rd,
  input  logic [NUM_BANK*DATA_WIDTH-1:0] din,
  output logic                         M_AXIS_TVALID,
  input  logic                         M_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]        M_AXIS_TDATA,
  output logic                         M_AXIS_TLAST
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         wc_q;
  logic [3:0]            bn_q;
  logic [3:0]            bank_idx;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  inflight;
  logic [3:0]            ifl_bank;
  logic                  ifl_last;

  logic [DATA_WIDTH-1:0] fifo_data [4];
  logic                  fifo_last [4];
  logic [1:0]            wr_ptr, rd_ptr;
  logic [2:0]            occ;

  logic [3:0]            bn_clamped;
  logic                  addr_last, bank_last;
  logic [2:0]            credit;
  logic                  issue, final_issue;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] push_data;

  assign bn_clamped  = (bank_num > 4'(NUM_BANK)) ? 4'(NUM_BANK) : bank_num;
  assign addr_last   = ({1'b0, addr} == (wc_q - CW'(1)));
  assign bank_last   = (bank_idx == (bn_q - 4'd1));
  assign credit      = occ + {2'b00, inflight};
  assign issue       = (state == S_READ) && (credit <= 3'd2);
  assign final_issue = issue && addr_last && bank_last;
  assign push        = inflight;
  assign pop         = M_AXIS_TVALID && M_AXIS_TREADY;

  always_comb begin
    push_data = '0;
    for (int k = 0; k < NUM_BANK; k++) begin
      if (ifl_bank == 4'(k)) push_data = din[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) state_nx = ((word_cnt == '0) || (bn_clamped == 4'd0)) ? S_DONE : S_READ;
      end
      S_READ: begin
        if (final_issue) state_nx = S_DRAIN;
      end
      // The final beat is the only entry left once it reaches the head.
      S_DRAIN: begin
        if (pop && fifo_last[rd_ptr] && (occ == 3'd1) && !inflight) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wc_q     <= '0;
      bn_q     <= '0;
      bank_idx <= '0;
      addr     <= '0;
      inflight <= 1'b0;
      ifl_bank <= '0;
      ifl_last <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      ifl_bank <= bank_idx;
      ifl_last <= final_issue;
      if ((state == S_IDLE) && start) begin
        wc_q     <= word_cnt;
        bn_q     <= bn_clamped;
        bank_idx <= '0;
        addr     <= '0;
      end else if (issue) begin
        if (addr_last) begin
          addr     <= '0;
          bank_idx <= bank_idx + 4'd1;
        end else begin
          addr <= addr + ADDR_WIDTH'(1);
        end
      end
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   occ <= occ + 3'd1;
        2'b01:   occ <= occ - 3'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_last[wr_ptr] <= ifl_last;
    end
  end

  assign busy          = (state == S_READ) || (state == S_DRAIN);
  assign done          = (state == S_DONE);
  assign en_rd         = issue ? (NUM_BANK'(1) << bank_idx) : '0;
  assign addr_rd       = issue ? addr : '0;
  assign M_AXIS_TVALID = (occ != 3'd0);
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? fifo_data[rd_ptr] : '0;
  assign M_AXIS_TLAST  = M_AXIS_TVALID && fifo_last[rd_ptr];

  assert property (@(posedge clk) disable iff (!rst) !(push && !pop && (occ == 3'd4)));
  assert property (@(posedge clk) disable iff (!rst) $onehot0(en_rd));

endmodule

// File: tb/tb_ofm_stream_tx.sv
// tb/tb_ofm_stream_tx.sv - directed table-driven bench for ofm_stream_tx
module tb_ofm_stream_tx;

  localparam int DW = 64;
  localparam int AW = 12;
  localparam int NB = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [AW:0]      word_cnt;
  logic [3:0]       bank_num;
  logic             busy, done;
  logic [NB-1:0]    en_rd;
  logic [AW-1:0]    addr_rd;
  logic [NB*DW-1:0] din;
  logic             tvalid, tready, tlast;
  logic [DW-1:0]    tdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ofm_stream_tx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANK(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .word_cnt(word_cnt), .bank_num(bank_num),
    .busy(busy), .done(done), .en_rd(en_rd), .addr_rd(addr_rd), .din(din),
    .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready), .M_AXIS_TDATA(tdata), .M_AXIS_TLAST(tlast)
  );

  function automatic logic [DW-1:0] bram_word(input int k, input int a);
    return {32'(k), 32'(a)};
  endfunction

  // Bank k holds {k, a} at address a; port B has one cycle of read latency.
  always @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (en_rd[k]) din[k*DW +: DW] <= bram_word(k, int'(addr_rd));
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int wc;
    int bn;
    int mode;        // 0: ready always, 1: ~30% ready, 2: ~50% ready
    int restart_at;  // cycle of an extra start pulse while busy, 0 = none
    int exp_beats;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v, input int idx);
    int beats = 0, issues = 0, tlast_cnt = 0, tlast_pos = -1;
    int done_cnt = 0, done_cyc = -1, last_hs = -1, first_valid = -1;
    int gaps = 0, data_errs = 0, stable_errs = 0, onehot_errs = 0;
    int max_out = 0, max_addr = 0, busy_c1 = 0, busy_at_done = 0;
    int wdiv, budget;
    bit prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic prev_last = 0;
    logic [DW-1:0] exp_word;
    string tag;
    tag = $sformatf("v%0d", idx);
    wdiv = (v.wc == 0) ? 1 : v.wc;
    budget = v.exp_beats * 20 + 60;
    word_cnt = (AW+1)'(v.wc);
    bank_num = 4'(v.bn);
    start = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      start = (c == v.restart_at);
      if (c == v.restart_at) begin
        word_cnt = 1;
        bank_num = 1;
      end
      case (v.mode)
        0:       tready = 1'b1;
        1:       tready = ($urandom_range(0, 9) < 3);
        default: tready = ($urandom_range(0, 1) == 1);
      endcase
      if (c == 1) busy_c1 = busy;
      if (prev_stall && (!tvalid || tdata !== prev_data || tlast !== prev_last)) stable_errs++;
      if (en_rd != '0) begin
        issues++;
        if (!$onehot(en_rd) || !busy) onehot_errs++;
        if (int'(addr_rd) > max_addr) max_addr = int'(addr_rd);
      end
      if (issues - beats > max_out) max_out = issues - beats;
      if (tvalid) begin
        if (first_valid < 0) first_valid = c;
      end else if (first_valid >= 0 && beats < v.exp_beats) begin
        gaps++;
      end
      if (tvalid && tready) begin
        exp_word = bram_word(beats / wdiv, beats % wdiv);
        if (tdata !== exp_word) data_errs++;
        if (tlast) begin
          tlast_cnt++;
          tlast_pos = beats;
        end
        beats++;
        last_hs = c;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
      if (done) begin
        done_cnt++;
        if (busy) busy_at_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    start = 1'b0;
    chk({tag, "_beats"}, beats, v.exp_beats);
    chk({tag, "_issues"}, issues, v.exp_beats);
    chk({tag, "_data_errs"}, data_errs, 0);
    chk({tag, "_tlast_cnt"}, tlast_cnt, (v.exp_beats > 0) ? 1 : 0);
    chk({tag, "_tlast_pos"}, tlast_pos, v.exp_beats - 1);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_busy_at_done"}, busy_at_done, 0);
    chk({tag, "_stable_errs"}, stable_errs, 0);
    chk({tag, "_onehot_errs"}, onehot_errs, 0);
    chk({tag, "_credit_ok"}, (max_out <= 4), 1);
    chk({tag, "_first_valid"}, first_valid, (v.exp_beats > 0) ? 3 : -1);
    chk({tag, "_max_addr"}, max_addr, (v.exp_beats > 0) ? v.wc - 1 : 0);
    if (v.exp_beats > 0) begin
      chk({tag, "_busy_c1"}, busy_c1, 1);
      chk({tag, "_done_cyc"}, done_cyc, last_hs + 1);
    end else begin
      chk({tag, "_done_cyc_le2"}, (done_cyc >= 1 && done_cyc <= 2), 1);
    end
    if (v.mode == 0) chk({tag, "_gaps"}, gaps, 0);
  endtask

  initial begin
    int beats;
    int early_tlast;
    vecs[0] = '{wc: 4,    bn: 2,  mode: 0, restart_at: 0, exp_beats: 8};
    vecs[1] = '{wc: 16,   bn: 8,  mode: 1, restart_at: 0, exp_beats: 128};
    vecs[2] = '{wc: 4096, bn: 1,  mode: 0, restart_at: 0, exp_beats: 4096};
    vecs[3] = '{wc: 0,    bn: 3,  mode: 0, restart_at: 0, exp_beats: 0};
    vecs[4] = '{wc: 5,    bn: 0,  mode: 0, restart_at: 0, exp_beats: 0};
    vecs[5] = '{wc: 1,    bn: 12, mode: 0, restart_at: 0, exp_beats: 8};
    vecs[6] = '{wc: 3,    bn: 8,  mode: 2, restart_at: 0, exp_beats: 24};
    vecs[7] = '{wc: 1,    bn: 1,  mode: 0, restart_at: 0, exp_beats: 1};
    vecs[8] = '{wc: 4,    bn: 2,  mode: 1, restart_at: 3, exp_beats: 8};

    rst = 1'b0;
    start = 1'b0;
    tready = 1'b0;
    word_cnt = '0;
    bank_num = '0;
    din = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_en_rd", en_rd, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset after the fifth beat of a 32-beat transfer.
    word_cnt = 4;
    bank_num = 8;
    tready = 1'b1;
    start = 1'b1;
    beats = 0;
    early_tlast = 0;
    for (int c = 1; c <= 100 && beats < 5; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (tvalid && tready) begin
        beats++;
        if (tlast) early_tlast++;
      end
    end
    chk("mid_beats_before_rst", beats, 5);
    chk("mid_early_tlast", early_tlast, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_en_rd", en_rd, 0);
    chk("mid_rst_addr_rd", addr_rd, 0);
    chk("mid_rst_tvalid", tvalid, 0);
    chk("mid_rst_tdata", tdata, 0);
    chk("mid_rst_tlast", tlast, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    run_vec('{wc: 2, bn: 1, mode: 0, restart_at: 0, exp_beats: 2}, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
